// File: rtl/jpeg_dec_seq.sv
// Frame-level decode sequencer: flushes the core, kicks one VLD run per ECS,
// counts output blocks until the frame drains, and reports errors/timeouts/aborts.
module jpeg_dec_seq #(
    parameter int unsigned TO_W = 24
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            START,
    input  logic            ABORT,
    input  logic [31:0]     C_BLK_TOT,
    input  logic [TO_W-1:0] C_TIMEOUT,
    input  logic            VLD_FIN,
    input  logic            VLD_ECS_FIN,
    input  logic [2:0]      ERR_INFO,
    input  logic            BLK_DONE,
    output logic            INIT,
    output logic            VLD_START,
    output logic            BUSY,
    output logic            DONE_IRQ,
    output logic            ERR_IRQ,
    output logic [4:0]      ERR_CODE,
    output logic [15:0]     ECS_CNT,
    output logic [31:0]     BLK_CNT
);

    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH, S_KICK, S_RUN, S_DRAIN, S_FAIL
    } state_t;

    state_t          state_q, state_d;
    logic            gap_q, gap_d;
    logic [31:0]     tot_q, tot_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            init_q, init_d;
    logic            vs_q, vs_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            erri_q, erri_d;
    logic [4:0]      code_q, code_d;
    logic [15:0]     ecs_q, ecs_d;
    logic [31:0]     blk_q, blk_d;

    logic            counting, err_active, wd_run, wd_clr;
    logic            abort_ev, vld_err, to_ev;
    logic [TO_W-1:0] wd_inc;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        tot_d   = tot_q;
        to_d    = to_q;
        wd_d    = wd_q;
        code_d  = code_q;
        ecs_d   = ecs_q;
        blk_d   = blk_q;
        done_d  = 1'b0;

        counting   = (state_q != S_IDLE) && (state_q != S_FAIL);
        err_active = (state_q == S_KICK) || (state_q == S_RUN) || (state_q == S_DRAIN);
        wd_run     = (state_q == S_RUN) || (state_q == S_DRAIN);
        wd_clr     = VLD_ECS_FIN || BLK_DONE;
        wd_inc     = wd_q + 1'b1;
        abort_ev   = ABORT && counting;
        vld_err    = err_active && (ERR_INFO != 3'b000);
        // Compare the incremented count so a limit of N fires after N idle cycles.
        to_ev      = wd_run && (to_q != '0) && !wd_clr && (wd_inc == to_q);

        if (counting && BLK_DONE && (blk_q != tot_q))
            blk_d = blk_q + 32'd1;

        if ((state_q == S_KICK) || wd_clr)
            wd_d = '0;
        else if (wd_run)
            wd_d = wd_inc;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    tot_d  = C_BLK_TOT;
                    to_d   = C_TIMEOUT;
                    wd_d   = '0;
                    ecs_d  = '0;
                    blk_d  = '0;
                    code_d = '0;
                    if (C_BLK_TOT == 32'd0)
                        done_d = 1'b1;
                    else
                        state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = S_KICK;
                gap_d   = 1'b0;
            end
            // A re-kick spends one quiet cycle in KICK before pulsing VLD_START.
            S_KICK: begin
                if (gap_q)
                    gap_d = 1'b0;
                else
                    state_d = S_RUN;
            end
            S_RUN: begin
                if (VLD_FIN) begin
                    state_d = S_DRAIN;
                end else if (VLD_ECS_FIN) begin
                    state_d = S_KICK;
                    gap_d   = 1'b1;
                end
            end
            S_DRAIN: begin
                if (blk_d == tot_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort_ev || vld_err || to_ev) begin
            state_d = S_FAIL;
            done_d  = 1'b0;
            code_d  = {abort_ev, to_ev, err_active ? ERR_INFO : 3'b000};
        end

        vs_d   = (state_d == S_KICK) && !gap_d;
        if (vs_d)
            ecs_d = ecs_q + 16'd1;
        init_d = (state_d == S_FLUSH) || (state_d == S_FAIL);
        busy_d = (state_d != S_IDLE);
        erri_d = (state_d == S_FAIL);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            gap_q   <= 1'b0;
            tot_q   <= '0;
            to_q    <= '0;
            wd_q    <= '0;
            init_q  <= 1'b0;
            vs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            erri_q  <= 1'b0;
            code_q  <= '0;
            ecs_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            tot_q   <= tot_d;
            to_q    <= to_d;
            wd_q    <= wd_d;
            init_q  <= init_d;
            vs_q    <= vs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            erri_q  <= erri_d;
            code_q  <= code_d;
            ecs_q   <= ecs_d;
            blk_q   <= blk_d;
        end
    end

    assign INIT      = init_q;
    assign VLD_START = vs_q;
    assign BUSY      = busy_q;
    assign DONE_IRQ  = done_q;
    assign ERR_IRQ   = erri_q;
    assign ERR_CODE  = code_q;
    assign ECS_CNT   = ecs_q;
    assign BLK_CNT   = blk_q;

endmodule

// File: tb/tb_jpeg_dec_seq.sv
// Self-checking bench for jpeg_dec_seq: vector table, hand-written corner cases
// and randomized frames checked against an event-timing reference model.
module tb_jpeg_dec_seq;

    localparam int unsigned TO_W = 24;

    logic            HCLK = 1'b0;
    logic            HRESET = 1'b1;
    logic            START = 1'b0, ABORT = 1'b0;
    logic [31:0]     C_BLK_TOT = '0;
    logic [TO_W-1:0] C_TIMEOUT = '0;
    logic            VLD_FIN = 1'b0, VLD_ECS_FIN = 1'b0, BLK_DONE = 1'b0;
    logic [2:0]      ERR_INFO = '0;
    logic            INIT, VLD_START, BUSY, DONE_IRQ, ERR_IRQ;
    logic [4:0]      ERR_CODE;
    logic [15:0]     ECS_CNT;
    logic [31:0]     BLK_CNT;

    jpeg_dec_seq #(.TO_W(TO_W)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .START(START), .ABORT(ABORT),
        .C_BLK_TOT(C_BLK_TOT), .C_TIMEOUT(C_TIMEOUT), .VLD_FIN(VLD_FIN),
        .VLD_ECS_FIN(VLD_ECS_FIN), .ERR_INFO(ERR_INFO), .BLK_DONE(BLK_DONE),
        .INIT(INIT), .VLD_START(VLD_START), .BUSY(BUSY), .DONE_IRQ(DONE_IRQ),
        .ERR_IRQ(ERR_IRQ), .ERR_CODE(ERR_CODE), .ECS_CNT(ECS_CNT), .BLK_CNT(BLK_CNT)
    );

    always #5 HCLK = ~HCLK;

    int total = 0, bad = 0, cyc = 0;
    int n_init, n_vs, n_done, n_err, done_c;
    int vs_q[$];

    typedef struct {
        int         tot;
        int         necs;
        int         run_blk;
        logic [2:0] err;
        int         abort_at;
        logic [4:0] x_code;
        int         x_ecs;
        int         x_blk;
        int         x_done;
        int         x_err;
        int         x_init;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr_tally();
        n_init = 0; n_vs = 0; n_done = 0; n_err = 0; done_c = -1;
        vs_q.delete();
    endtask

    // One clock: inputs driven before the call are sampled, pulses are then dropped.
    task automatic step();
        @(posedge HCLK);
        #1;
        cyc++;
        START = 1'b0; ABORT = 1'b0; VLD_FIN = 1'b0; VLD_ECS_FIN = 1'b0;
        BLK_DONE = 1'b0; ERR_INFO = '0;
        if (INIT) n_init++;
        if (VLD_START) begin n_vs++; vs_q.push_back(cyc); end
        if (DONE_IRQ) begin n_done++; if (done_c < 0) done_c = cyc; end
        if (ERR_IRQ) n_err++;
    endtask

    function automatic logic [63:0] outs();
        return {6'b0, INIT, VLD_START, BUSY, DONE_IRQ, ERR_IRQ, ERR_CODE, ECS_CNT, BLK_CNT};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        clr_tally();
        C_BLK_TOT = v.tot;
        C_TIMEOUT = '0;
        START = 1'b1; step();
        chk($sformatf("v%0d_start_lat", idx), {INIT, BUSY, VLD_START}, 3'b110);
        chk($sformatf("v%0d_start_clear", idx), {ERR_CODE, ECS_CNT, BLK_CNT}, 0);
        step();
        chk($sformatf("v%0d_kick_lat", idx), VLD_START, 1);
        step();
        for (int e = 1; e < v.necs; e++) begin
            step(); step();
            VLD_ECS_FIN = 1'b1; step();
            chk($sformatf("v%0d_ecs_gap", idx), VLD_START, 0);
            step();
            chk($sformatf("v%0d_ecs_kick", idx), VLD_START, 1);
            step();
        end
        for (int i = 0; i < v.run_blk; i++) begin BLK_DONE = 1'b1; step(); end
        VLD_FIN = 1'b1; VLD_ECS_FIN = (v.necs > 1); ERR_INFO = v.err; step();
        for (int k = 0; k < 40 && BUSY; k++) begin
            if (k == v.abort_at) begin ABORT = 1'b1; START = 1'b1; end
            else BLK_DONE = 1'b1;
            step();
        end
        chk($sformatf("v%0d_busy_fall", idx), BUSY, 0);
        chk($sformatf("v%0d_done_at_fall", idx), DONE_IRQ, v.x_done);
        repeat (3) step();
        chk($sformatf("v%0d_code", idx), ERR_CODE, v.x_code);
        chk($sformatf("v%0d_ecs_cnt", idx), ECS_CNT, v.x_ecs);
        chk($sformatf("v%0d_blk_cnt", idx), BLK_CNT, v.x_blk);
        chk($sformatf("v%0d_n_done", idx), n_done, v.x_done);
        chk($sformatf("v%0d_n_errirq", idx), n_err, v.x_err);
        chk($sformatf("v%0d_n_init", idx), n_init, v.x_init);
        chk($sformatf("v%0d_n_vstart", idx), n_vs, v.x_ecs);
    endtask

    // Reference: plan a frame as event times, predict pulse times from the rules.
    task automatic rand_frame(input int idx);
        bit blk_s[256];
        bit ecs_s[256];
        bit fin_s[256];
        int tot, necs, run_start, ec, f, cnt, c_tot, done_x, base, nv;
        int x_vs[$];
        tot  = int'($urandom_range(1, 20));
        necs = int'($urandom_range(1, 4));
        foreach (blk_s[i]) begin ecs_s[i] = 1'b0; fin_s[i] = 1'b0; end
        run_start = 3;
        x_vs.push_back(2);
        for (int e = 1; e < necs; e++) begin
            ec = run_start + int'($urandom_range(0, 4));
            ecs_s[ec] = 1'b1;
            x_vs.push_back(ec + 2);
            run_start = ec + 3;
        end
        f = run_start + int'($urandom_range(0, 4));
        fin_s[f] = 1'b1;
        if (necs > 1 && $urandom_range(0, 1) == 1) ecs_s[f] = 1'b1;
        foreach (blk_s[i]) blk_s[i] = (i >= 100) || ($urandom_range(0, 2) == 0);
        cnt = 0; c_tot = -1;
        for (int c = 1; c < 256; c++)
            if (blk_s[c]) begin
                cnt++;
                if (cnt == tot && c_tot < 0) c_tot = c;
            end
        done_x = ((c_tot > f + 1) ? c_tot : f + 1) + 1;

        clr_tally();
        C_TIMEOUT = '0;
        C_BLK_TOT = tot;
        base = cyc;
        for (int c = 0; c < 250 && done_c < 0; c++) begin
            START = (c == 0); VLD_ECS_FIN = ecs_s[c]; VLD_FIN = fin_s[c]; BLK_DONE = blk_s[c];
            step();
            if (c == 0) C_BLK_TOT = $urandom;
        end
        chk($sformatf("r%0d_done_cyc", idx), done_c - base, done_x);
        chk($sformatf("r%0d_n_vstart", idx), vs_q.size(), x_vs.size());
        nv = (vs_q.size() < x_vs.size()) ? vs_q.size() : x_vs.size();
        for (int i = 0; i < nv; i++)
            chk($sformatf("r%0d_vstart%0d_cyc", idx, i), vs_q[i] - base, x_vs[i]);
        chk($sformatf("r%0d_blk_cnt", idx), BLK_CNT, tot);
        chk($sformatf("r%0d_ecs_cnt", idx), ECS_CNT, necs);
        chk($sformatf("r%0d_code", idx), ERR_CODE, 0);
        chk($sformatf("r%0d_n_errirq", idx), n_err, 0);
        chk($sformatf("r%0d_n_init", idx), n_init, 1);
        repeat (2) step();
    endtask

    initial begin
        int n;
        //         tot necs run err    abort code      ecs blk done err init
        vt[0] = '{6,  1,   0,  3'b000, -1,  5'b00000, 1,  6,  1,   0,  1};
        vt[1] = '{12, 3,   0,  3'b000, -1,  5'b00000, 3,  12, 1,   0,  1};
        vt[2] = '{6,  1,   0,  3'b010, -1,  5'b00010, 1,  0,  0,   1,  2};
        vt[3] = '{6,  1,   0,  3'b000, 2,   5'b10000, 1,  2,  0,   1,  2};
        vt[4] = '{4,  2,   4,  3'b000, -1,  5'b00000, 2,  4,  1,   0,  1};
        vt[5] = '{3,  1,   5,  3'b000, -1,  5'b00000, 1,  3,  1,   0,  1};
        vt[6] = '{5,  2,   2,  3'b111, -1,  5'b00111, 2,  2,  0,   1,  2};

        step(); step();
        chk("reset_outputs", outs(), 0);
        HRESET = 1'b0;
        step();

        clr_tally();
        C_BLK_TOT = 0; START = 1'b1; step();
        chk("zero_done", {DONE_IRQ, BUSY, INIT}, 3'b100);
        step();
        chk("zero_done_pulse", DONE_IRQ, 0);
        repeat (3) step();
        chk("zero_no_init", n_init + n_vs, 0);

        C_BLK_TOT = 6; START = 1'b1; step(); step(); step();
        BLK_DONE = 1'b1; step();
        chk("pre_reset_blk", BLK_CNT, 1);
        HRESET = 1'b1; step();
        chk("reset_mid_run", outs(), 0);
        HRESET = 1'b0;
        clr_tally();
        step(); step();
        chk("no_init_after_reset", {28'b0, n_init, BUSY}, 0);

        foreach (vt[i]) run_vec(vt[i], i);

        clr_tally();
        C_BLK_TOT = 6; C_TIMEOUT = 100; START = 1'b1; step(); step();
        chk("wd_kick", VLD_START, 1);
        n = 0;
        do begin step(); n++; end while (!ERR_IRQ && n < 300);
        chk("wd_latency", n, 101);
        chk("wd_code", ERR_CODE, 5'b01000);
        chk("wd_init_with_err", INIT, 1);
        step();
        chk("wd_idle", BUSY, 0);

        C_TIMEOUT = 0; START = 1'b1; step();
        clr_tally();
        repeat (10000) step();
        chk("wd_off_no_err", n_err, 0);
        chk("wd_off_busy", BUSY, 1);
        ABORT = 1'b1; ERR_INFO = 3'b101; step();
        chk("abort_info_code", ERR_CODE, 5'b10101);
        chk("abort_pulses", {ERR_IRQ, INIT}, 2'b11);
        step();
        chk("abort_idle", BUSY, 0);
        ABORT = 1'b1; step(); step();
        chk("abort_in_idle", {ERR_IRQ, INIT, BUSY}, 0);

        for (int r = 0; r < 20; r++) rand_frame(r);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got sim time %0t expected completion", $time);
        $fatal(1, "bench timeout");
    end

endmodule
